ex_mem_reg: RTL and testbench
=============================

// Module: ex_mem_reg
// PURPOSE
//  EX->MEM pipeline register of the OpenMIPS 5-stage core. Captures the execute-stage
//  result (dest reg addr/enable/data, HI/LO write) on each rising clk and presents it to
//  the combinational MEM stage. Handles pipeline stall (hold / bubble insertion) and flush.
//  Also carries the two-cycle madd/msub temporary (hilo_temp, cnt) back to EX during stall.
// PARAMETERS
//  ADDR_W   5   register-file address width
//  DATA_W   32  datapath width; HI/LO temporary is 2*DATA_W
//  STALL_W  6   width of stall vector from ctrl (pc,if,id,ex,mem,wb)
//  EX_IDX   3   stall bit index of EX stage
//  MEM_IDX  4   stall bit index of MEM stage
// PORTS
//  clk        in   1         core clock, rising edge
//  rst        in   1         asynchronous, active-low reset
//  stall      in   STALL_W   per-stage stall from ctrl
//  flush      in   1         synchronous pipeline flush (exception)
//  ex_wd      in   ADDR_W    EX dest reg address
//  ex_wreg    in   1         EX dest reg write enable
//  ex_wdata   in   DATA_W    EX dest reg data
//  ex_hi      in   DATA_W    EX HI value
//  ex_lo      in   DATA_W    EX LO value
//  ex_whilo   in   1         EX HI/LO write enable
//  hilo_i     in   2*DATA_W  madd/msub first-cycle product from EX
//  cnt_i      in   2         madd/msub cycle counter from EX
//  mem_wd     out  ADDR_W    to MEM wd_i
//  mem_wreg   out  1         to MEM wreg_i
//  mem_wdata  out  DATA_W    to MEM wdata_i
//  mem_hi     out  DATA_W    to MEM HI
//  mem_lo     out  DATA_W    to MEM LO
//  mem_whilo  out  1         to MEM HI/LO write enable
//  hilo_o     out  2*DATA_W  held product back to EX
//  cnt_o      out  2         held counter back to EX
// BEHAVIOUR
//  - rst low (async): mem_wd=NOPRegAddr(0), mem_wreg=WriteDisable(0), mem_wdata/hi/lo=0,
//    mem_whilo=0, hilo_o=0, cnt_o=0. Released synchronously by ctrl; no state survives.
//  - Latency 1 cycle: value on ex_* before edge N is on mem_* after edge N.
//  - Priority per edge (highest first):
//    1 flush=1: all outputs to reset values (incl. hilo_o/cnt_o), regardless of stall.
//    2 stall[EX_IDX]=1, stall[MEM_IDX]=0: bubble -> mem_* to reset values;
//      hilo_o<=hilo_i, cnt_o<=cnt_i (preserve madd/msub progress).
//    3 stall[EX_IDX]=1, stall[MEM_IDX]=1: hold all outputs.
//    4 stall[EX_IDX]=0: load mem_*<=ex_*; hilo_o<=0, cnt_o<=0.
//  - stall[MEM_IDX]=1 with stall[EX_IDX]=0 is illegal from ctrl; treated as hold (3).
//  - Bubble is the only way a NOP enters MEM; never pass ex_* while EX stalled.
//  - cnt_o only 2'b00/2'b01 legal; values pass unmodified, no arithmetic in this block.
//  - All outputs registered; no combinational ex_*->mem_* path.
// STRUCTURE
//  - Shared defines.v: RstEnable(1'b0), ZeroWord, NOPRegAddr, WriteDisable, Stop/NoStop,
//    RegAddrBus, RegBus, DoubleRegBus; stall bit indices also defined there.
//  - Single always block with async reset; no sub-module. Decode of the four cases
//    in a small combinational next-state mux; pure flop stage otherwise.
// TESTING
//  - Reset: rst=0 mid-run with mem_wreg=1 -> all outputs 0 immediately, before next edge.
//  - Pass: ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h0000_1234, stall=0 -> next edge
//    mem_wd=3, mem_wreg=1, mem_wdata=32'h1234; hilo_o=0, cnt_o=0.
//  - Bubble: stall=6'b001111, hilo_i=64'h1_0000_0002, cnt_i=1 -> mem_wreg=0, mem_wd=0,
//    hilo_o=64'h1_0000_0002, cnt_o=1; release stall -> ex_* loaded, cnt_o=0.
//  - Hold: stall=6'b011111 for 3 cycles with ex_* toggling -> mem_*, hilo_o, cnt_o unchanged.
//  - Flush: flush=1 with stall=6'b001111 and cnt_i=1 -> all outputs 0 incl. cnt_o.
//  - HI/LO: ex_whilo=1, ex_hi=32'hDEAD_BEEF, ex_lo=32'h1 -> mem_whilo=1, mem_hi/lo match.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// Shared constants and the per-edge action decode for the EX->MEM pipeline register.
package ex_mem_reg_pkg;

  // Reset level and control-bit encodings used by the whole core
  localparam logic RST_ENABLE    = 1'b0;
  localparam logic STOP          = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // What the pipeline register does on the next rising edge
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_FLUSH  = 2'd3
  } stage_act_e;

  // Flush beats everything. A stalled EX feeding a running MEM must inject a
  // bubble so the same instruction is not executed twice in MEM. MEM stalled
  // while EX runs cannot come from ctrl; holding is the safe interpretation.
  function automatic stage_act_e decode_act(input logic flush,
                                            input logic ex_stall,
                                            input logic mem_stall);
    stage_act_e act;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (ex_stall == STOP) begin
      act = (mem_stall == STOP) ? ACT_HOLD : ACT_BUBBLE;
    end else if (mem_stall == STOP) begin
      act = ACT_HOLD;
    end else begin
      act = ACT_LOAD;
    end
    return act;
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: captures execute results for the memory stage,
// handles stall (hold / bubble) and flush, and returns the madd/msub
// first-cycle product and cycle counter to EX while EX is stalled.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6,
  parameter int EX_IDX  = 3,
  parameter int MEM_IDX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [1:0]            cnt_i,
  output logic [ADDR_W-1:0]     mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [1:0]            cnt_o
);

  logic [ADDR_W-1:0]   mem_wd_q,    mem_wd_d;
  logic                mem_wreg_q,  mem_wreg_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   mem_hi_q,    mem_hi_d;
  logic [DATA_W-1:0]   mem_lo_q,    mem_lo_d;
  logic                mem_whilo_q, mem_whilo_d;
  logic [2*DATA_W-1:0] hilo_q,      hilo_d;
  logic [1:0]          cnt_q,       cnt_d;
  stage_act_e          act;

  // Only the EX and MEM stall bits matter here; the rest of the vector
  // belongs to other stages.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall;

  // Next-state mux: decode the edge action, then pick hold / bubble / load / clear
  always_comb begin
    act         = decode_act(flush, stall[EX_IDX], stall[MEM_IDX]);
    mem_wd_d    = mem_wd_q;
    mem_wreg_d  = mem_wreg_q;
    mem_wdata_d = mem_wdata_q;
    mem_hi_d    = mem_hi_q;
    mem_lo_d    = mem_lo_q;
    mem_whilo_d = mem_whilo_q;
    hilo_d      = hilo_q;
    cnt_d       = cnt_q;
    case (act)
      ACT_FLUSH: begin
        mem_wd_d    = '0;
        mem_wreg_d  = WRITE_DISABLE;
        mem_wdata_d = '0;
        mem_hi_d    = '0;
        mem_lo_d    = '0;
        mem_whilo_d = WRITE_DISABLE;
        hilo_d      = '0;
        cnt_d       = '0;
      end
      ACT_BUBBLE: begin
        mem_wd_d    = '0;
        mem_wreg_d  = WRITE_DISABLE;
        mem_wdata_d = '0;
        mem_hi_d    = '0;
        mem_lo_d    = '0;
        mem_whilo_d = WRITE_DISABLE;
        hilo_d      = hilo_i;
        cnt_d       = cnt_i;
      end
      ACT_LOAD: begin
        mem_wd_d    = ex_wd;
        mem_wreg_d  = ex_wreg;
        mem_wdata_d = ex_wdata;
        mem_hi_d    = ex_hi;
        mem_lo_d    = ex_lo;
        mem_whilo_d = ex_whilo;
        hilo_d      = '0;
        cnt_d       = '0;
      end
      default: begin
      end
    endcase
  end

  // Pipeline flops with asynchronous active-low reset to the NOP state
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      mem_wd_q    <= '0;
      mem_wreg_q  <= WRITE_DISABLE;
      mem_wdata_q <= '0;
      mem_hi_q    <= '0;
      mem_lo_q    <= '0;
      mem_whilo_q <= WRITE_DISABLE;
      hilo_q      <= '0;
      cnt_q       <= '0;
    end else begin
      mem_wd_q    <= mem_wd_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_wdata_q <= mem_wdata_d;
      mem_hi_q    <= mem_hi_d;
      mem_lo_q    <= mem_lo_d;
      mem_whilo_q <= mem_whilo_d;
      hilo_q      <= hilo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_wd    = mem_wd_q;
  assign mem_wreg  = mem_wreg_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_hi    = mem_hi_q;
  assign mem_lo    = mem_lo_q;
  assign mem_whilo = mem_whilo_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: directed vectors push hand-computed
// expected outputs; a monitor pops and compares them after each edge.
module tb_ex_mem_reg;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } ins_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } outs_t;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int num_checks = 0;
  int num_errors = 0;
  outs_t exp_q[$];
  string name_q[$];

  ex_mem_reg dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
    .ex_hi     (ex_hi),
    .ex_lo     (ex_lo),
    .ex_whilo  (ex_whilo),
    .hilo_i    (hilo_i),
    .cnt_i     (cnt_i),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .hilo_o    (hilo_o),
    .cnt_o     (cnt_o)
  );

  // Free-running core clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic ins_t vin(input logic [5:0] st, input logic fl,
                               input logic [4:0] wd, input logic wreg,
                               input logic [31:0] wdata, input logic [31:0] hi,
                               input logic [31:0] lo, input logic whilo,
                               input logic [63:0] hilo, input logic [1:0] cnt);
    ins_t v;
    v.stall = st;  v.flush = fl;  v.wd = wd;  v.wreg = wreg;
    v.wdata = wdata;  v.hi = hi;  v.lo = lo;  v.whilo = whilo;
    v.hilo = hilo;  v.cnt = cnt;
    return v;
  endfunction

  function automatic outs_t vout(input logic [4:0] wd, input logic wreg,
                                 input logic [31:0] wdata, input logic [31:0] hi,
                                 input logic [31:0] lo, input logic whilo,
                                 input logic [63:0] hilo, input logic [1:0] cnt);
    outs_t v;
    v.wd = wd;  v.wreg = wreg;  v.wdata = wdata;  v.hi = hi;
    v.lo = lo;  v.whilo = whilo;  v.hilo = hilo;  v.cnt = cnt;
    return v;
  endfunction

  // Compare the DUT outputs as a whole against one expected record
  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = vout(mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b hilo=%h cnt=%h, expected wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b hilo=%h cnt=%h",
               name, act.wd, act.wreg, act.wdata, act.hi, act.lo, act.whilo, act.hilo, act.cnt,
               exp.wd, exp.wreg, exp.wdata, exp.hi, exp.lo, exp.whilo, exp.hilo, exp.cnt);
    end
  endtask

  // Drive one vector away from the edge, then queue its result for the monitor
  task automatic applyStimulus(input string name, input ins_t v, input outs_t exp);
    @(negedge clk);
    stall    = v.stall;
    flush    = v.flush;
    ex_wd    = v.wd;
    ex_wreg  = v.wreg;
    ex_wdata = v.wdata;
    ex_hi    = v.hi;
    ex_lo    = v.lo;
    ex_whilo = v.whilo;
    hilo_i   = v.hilo;
    cnt_i    = v.cnt;
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  // Monitor: after each edge the outputs are stable, so pop and compare
  initial begin
    outs_t e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checkOutput(n, e);
      end
    end
  end

  // Directed stimulus sequence
  initial begin
    outs_t zero;
    outs_t held;
    zero = '0;
    rst = 1'b0;  stall = '0;  flush = 1'b0;  ex_wd = '0;  ex_wreg = 1'b0;
    ex_wdata = '0;  ex_hi = '0;  ex_lo = '0;  ex_whilo = 1'b0;
    hilo_i = '0;  cnt_i = '0;

    exp_q.push_back(zero);
    name_q.push_back("reset_init");
    @(negedge clk);
    #1 rst = 1'b1;

    applyStimulus("pass", vin(6'b000000, 0, 5'd3, 1, 32'h0000_1234, 32'h0, 32'h0, 0, 64'h55, 2'd1),
                  vout(5'd3, 1, 32'h0000_1234, 32'h0, 32'h0, 0, 64'h0, 2'd0));
    applyStimulus("hilo", vin(6'b000000, 0, 5'd7, 1, 32'hAA, 32'hDEAD_BEEF, 32'h1, 1, 64'h0, 2'd0),
                  vout(5'd7, 1, 32'hAA, 32'hDEAD_BEEF, 32'h1, 1, 64'h0, 2'd0));
    applyStimulus("bubble", vin(6'b001111, 0, 5'd9, 1, 32'h77, 32'h5, 32'h6, 1, 64'h1_0000_0002, 2'd1),
                  vout(5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 64'h1_0000_0002, 2'd1));
    applyStimulus("release", vin(6'b000000, 0, 5'd4, 1, 32'h4444, 32'h0, 32'h0, 0, 64'h1_0000_0002, 2'd1),
                  vout(5'd4, 1, 32'h4444, 32'h0, 32'h0, 0, 64'h0, 2'd0));

    held = vout(5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 64'hABCD_0000_1111_2222, 2'd1);
    applyStimulus("bubble2", vin(6'b001111, 0, 5'd12, 1, 32'h1200, 32'h0, 32'h0, 0, 64'hABCD_0000_1111_2222, 2'd1),
                  held);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("hold_bubble", vin(6'b011111, 0, 5'(20 + i), i[0], 32'h100 + i, 32'h7 + i, 32'h9 + i, ~i[0],
                                       64'hFFFF + i, 2'd0), held);
    end

    held = vout(5'd15, 1, 32'hCAFE, 32'h11, 32'h22, 1, 64'h0, 2'd0);
    applyStimulus("load", vin(6'b000000, 0, 5'd15, 1, 32'hCAFE, 32'h11, 32'h22, 1, 64'h77, 2'd1), held);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("hold_load", vin(6'b011111, 0, 5'(i), 0, 32'(i), 32'h0, 32'h0, 0, 64'h3, 2'd1), held);
    end
    applyStimulus("illegal_mem_stall", vin(6'b010000, 0, 5'd1, 0, 32'h1, 32'h2, 32'h3, 0, 64'h8, 2'd1), held);

    applyStimulus("bubble3", vin(6'b001111, 0, 5'd2, 1, 32'h2, 32'h0, 32'h0, 0, 64'h99, 2'd1),
                  vout(5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 64'h99, 2'd1));
    applyStimulus("flush_bubble", vin(6'b001111, 1, 5'd3, 1, 32'h3, 32'h3, 32'h3, 1, 64'h1234, 2'd1), zero);
    applyStimulus("load2", vin(6'b000000, 0, 5'd10, 1, 32'hBEEF, 32'h1, 32'h2, 1, 64'h5, 2'd1),
                  vout(5'd10, 1, 32'hBEEF, 32'h1, 32'h2, 1, 64'h0, 2'd0));
    applyStimulus("flush_run", vin(6'b000000, 1, 5'd11, 1, 32'h11, 32'h4, 32'h5, 1, 64'h6, 2'd1), zero);
    applyStimulus("load3", vin(6'b000000, 0, 5'd5, 1, 32'h55, 32'h0, 32'h0, 0, 64'h0, 2'd0),
                  vout(5'd5, 1, 32'h55, 32'h0, 32'h0, 0, 64'h0, 2'd0));
    applyStimulus("flush_hold", vin(6'b011111, 1, 5'd6, 1, 32'h66, 32'h1, 32'h1, 1, 64'h2, 2'd1), zero);
    applyStimulus("load_max", vin(6'b000000, 0, 5'd31, 1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1,
                                  64'h0, 2'd0),
                  vout(5'd31, 1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1, 64'h0, 2'd0));

    // Asynchronous reset mid-cycle: outputs must clear before the next edge
    @(negedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("async_reset", zero);
    @(posedge clk);
    #1 checkOutput("reset_held", zero);
    @(negedge clk);
    #1 rst = 1'b1;

    applyStimulus("after_reset", vin(6'b000000, 0, 5'd6, 1, 32'h66, 32'h0, 32'h0, 0, 64'h0, 2'd0),
                  vout(5'd6, 1, 32'h66, 32'h0, 32'h0, 0, 64'h0, 2'd0));

    // Give the monitor a bounded window to drain the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() > 0) begin
      num_checks++;
      num_errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
